// File: rtl/mem_stage_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_unit
//
// MEM-stage data-memory interface for the pipelined RV32I core. Takes the
// EX/MEM control word (mem_read, mem_write, funct3), the ALU byte address and
// the forwarded rs2 value. It issues one access at a time to a single-ported
// data memory using a request/resp handshake, and stalls the pipeline until
// that access retires. It produces lane-replicated store data, a byte mask and
// the sign/zero-extended load result for MEM/WB.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            EX/MEM holds a valid instruction
//   mem_read/mem_write  access kind from the control word
//   funct3              load/store width and signedness
//   addr                byte address (ALU result)
//   store_data          rs2 value for stores
//   data_mem_address    word-aligned address of the current access
//   data_mem_read/write request, held high for the whole BUSY phase
//   data_mem_wdata      store data replicated across the byte lanes
//   data_mem_wmask      byte enables (0000 for loads)
//   data_mem_rdata      read data, valid together with data_mem_resp
//   data_mem_resp       one-cycle completion pulse from the memory
//   stall               freeze PC and upstream pipeline registers
//   load_data           extended load result, valid while done=1
//   done                one-cycle pulse: access retired normally
//   fault               one-cycle pulse: misaligned, illegal or timed out
// -----------------------------------------------------------------------------
module mem_stage_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] data_mem_address,
    output logic        data_mem_read,
    output logic        data_mem_write,
    output logic [31:0] data_mem_wdata,
    output logic [3:0]  data_mem_wmask,
    input  logic [31:0] data_mem_rdata,
    input  logic        data_mem_resp,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      address_reg,   address_next;
    logic [31:0]      wdata_reg,     wdata_next;
    logic [3:0]       wmask_reg,     wmask_next;
    logic [2:0]       funct3_reg,    funct3_next;
    logic [1:0]       offset_reg,    offset_next;
    logic             is_read_reg,   is_read_next;
    logic             is_write_reg,  is_write_next;
    logic [CNT_W-1:0] wait_cnt_reg,  wait_cnt_next;
    logic [31:0]      load_data_reg, load_data_next;
    logic             aborted_reg,   aborted_next;
    logic             fault_reg,     fault_next;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic mem_op;
    logic single_kind;
    logic legal_funct3;
    logic is_aligned;
    logic start;
    logic reject;

    always_comb begin
        mem_op      = in_valid & (mem_read | mem_write);
        single_kind = mem_read ^ mem_write;

        // Unsigned variants (100/101) only exist for loads.
        case (funct3)
            3'b000, 3'b001, 3'b010: legal_funct3 = 1'b1;
            3'b100, 3'b101:         legal_funct3 = mem_read;
            default:                legal_funct3 = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~addr[0];
            2'b10:   is_aligned = (addr[1:0] == 2'b00);
            default: is_aligned = 1'b0;
        endcase

        start  = mem_op & single_kind & legal_funct3 & is_aligned;
        reject = mem_op & ~start;
    end

    // ------------------------------------------------------------------
    // Store lane steering: each byte lane picks its source byte and decides
    // whether it is enabled, based on access width and address offset.
    // ------------------------------------------------------------------
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [7:0]  rdata_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wdata[gi*8 +: 8] =
                (funct3[1:0] == 2'b00) ? store_data[7:0] :
                (funct3[1:0] == 2'b01) ? store_data[(gi % 2)*8 +: 8] :
                                         store_data[gi*8 +: 8];

            assign lane_wmask[gi] =
                (funct3[1:0] == 2'b10) |
                ((funct3[1:0] == 2'b01) & (addr[1] == 1'(gi / 2))) |
                ((funct3[1:0] == 2'b00) & (addr[1:0] == 2'(gi)));

            assign rdata_byte[gi] = data_mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load extraction using the offset captured at accept time
    // ------------------------------------------------------------------
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    always_comb begin
        sel_byte = rdata_byte[offset_reg];
        sel_half = offset_reg[1] ? data_mem_rdata[31:16] : data_mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  ext_data = data_mem_rdata;
            3'b100:  ext_data = {24'h0, sel_byte};
            3'b101:  ext_data = {16'h0, sel_half};
            default: ext_data = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             wait_expired;

    always_comb begin
        wait_cnt_inc = wait_cnt_reg + CNT_W'(1);
        wait_expired = (wait_cnt_inc == CNT_W'(MAX_WAIT));

        state_next     = state_reg;
        address_next   = address_reg;
        wdata_next     = wdata_reg;
        wmask_next     = wmask_reg;
        funct3_next    = funct3_reg;
        offset_next    = offset_reg;
        is_read_next   = is_read_reg;
        is_write_next  = is_write_reg;
        wait_cnt_next  = wait_cnt_reg;
        load_data_next = load_data_reg;
        aborted_next   = aborted_reg;
        fault_next     = 1'b0;
        stall          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Stall in the accept cycle so the instruction stays put.
                    stall         = 1'b1;
                    address_next  = {addr[31:2], 2'b00};
                    wdata_next    = mem_write ? lane_wdata : 32'h0;
                    wmask_next    = mem_write ? lane_wmask : 4'b0000;
                    funct3_next   = funct3;
                    offset_next   = addr[1:0];
                    is_read_next  = mem_read;
                    is_write_next = mem_write;
                    wait_cnt_next = '0;
                    aborted_next  = 1'b0;
                    state_next    = BUSY;
                end else if (reject) begin
                    // No access; downstream squashes on the fault pulse.
                    fault_next = 1'b1;
                end
            end

            BUSY: begin
                stall = 1'b1;
                if (data_mem_resp) begin
                    load_data_next = is_read_reg ? ext_data : 32'h0;
                    state_next     = DONE;
                end else if (wait_expired) begin
                    fault_next     = 1'b1;
                    aborted_next   = 1'b1;
                    load_data_next = 32'h0;
                    state_next     = DONE;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            address_reg   <= 32'h0;
            wdata_reg     <= 32'h0;
            wmask_reg     <= 4'b0000;
            funct3_reg    <= 3'b000;
            offset_reg    <= 2'b00;
            is_read_reg   <= 1'b0;
            is_write_reg  <= 1'b0;
            wait_cnt_reg  <= '0;
            load_data_reg <= 32'h0;
            aborted_reg   <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            address_reg   <= address_next;
            wdata_reg     <= wdata_next;
            wmask_reg     <= wmask_next;
            funct3_reg    <= funct3_next;
            offset_reg    <= offset_next;
            is_read_reg   <= is_read_next;
            is_write_reg  <= is_write_next;
            wait_cnt_reg  <= wait_cnt_next;
            load_data_reg <= load_data_next;
            aborted_reg   <= aborted_next;
            fault_reg     <= fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: request lines come straight from registers
    // ------------------------------------------------------------------
    assign data_mem_address = address_reg;
    assign data_mem_wdata   = wdata_reg;
    assign data_mem_wmask   = wmask_reg;
    assign data_mem_read    = (state_reg == BUSY) & is_read_reg;
    assign data_mem_write   = (state_reg == BUSY) & is_write_reg;
    assign load_data        = load_data_reg;
    assign done             = (state_reg == DONE) & ~aborted_reg;
    assign fault            = fault_reg;

endmodule
